fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port (wr_en / data_in / full) among NUM_REQ producers. Each producer uses a valid/ready handshake. A granted producer holds the port for a burst of up to MAX_BURST beats before the grant rotates. Sits directly in front of the sync FIFO; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ valid/ready producers.
// Latency: 1 arbitration cycle in IDLE, then one beat per cycle straight through to the FIFO.
// Backpressure: fifo_full drops the granted req_ready; the grant is held and the beat is not counted.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   req_valid/req_ready  - per-producer handshake; producer i data in req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full/fifo_wr_en/fifo_data_in - FIFO write port
//   grant_valid/grant_id - current (or last) grant holder
//   stat_sel/stat_clr/stat_count - per-producer written-beat counters, present only
//                          when FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          grant_valid,
   output logic [ID_WIDTH-1:0]           grant_id
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic [ID_WIDTH-1:0]           stat_sel,
   input  logic                          stat_clr,
   output logic [15:0]                   stat_count
`endif
);

   localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
   localparam logic [ID_WIDTH:0] NREQ      = (ID_WIDTH+1)'(NUM_REQ);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;
   logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

   logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
   logic                  gnt_vld;
   logic                  xfer;
   logic                  arb_found;
   logic [ID_WIDTH-1:0]   arb_winner;
   logic [ID_WIDTH:0]     cand;
   logic [ID_WIDTH:0]     gnt_inc;
   logic [ID_WIDTH-1:0]   next_ptr;

   // Unpack the flat producer data bus.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   assign gnt_vld = req_valid[grant_id_q];

   // A beat moves only in BURST with the owner valid and FIFO space; a beat
   // presented during reset is dropped so nothing is written mid-reset.
   assign xfer = (state_q == BURST) && gnt_vld && !fifo_full && !rst;

   // Rotating priority search starting at rr_ptr. The candidate index is
   // reduced modulo NUM_REQ explicitly so non-power-of-two counts wrap correctly.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!arb_found && req_valid[cand[ID_WIDTH-1:0]]) begin
            arb_found  = 1'b1;
            arb_winner = cand[ID_WIDTH-1:0];
         end
      end
   end

   // Pointer handed back on burst exit: owner + 1, wrapping at NUM_REQ.
   always_comb begin
      gnt_inc  = {1'b0, grant_id_q} + (ID_WIDTH+1)'(1);
      next_ptr = gnt_inc[ID_WIDTH-1:0];
      if (gnt_inc >= NREQ) begin
         next_ptr = '0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d    = BURST;
               grant_id_d = arb_winner;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            if (!gnt_vld) begin
               // Owner went idle: release without writing.
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end else if (xfer) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
               end
            end
            // Owner valid but FIFO full: hold everything, cycle not counted.
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs.
   always_comb begin
      req_ready = '0;
      if ((state_q == BURST) && !fifo_full && !rst) begin
         req_ready[grant_id_q] = 1'b1;
      end
   end

   assign fifo_wr_en   = xfer;
   assign fifo_data_in = req_data_arr[grant_id_q];
   assign grant_valid  = (state_q == BURST);
   assign grant_id     = grant_id_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_cnt_q [NUM_REQ];
   logic [15:0] stat_cnt_d [NUM_REQ];

   // Saturating per-producer beat counters; clear wins over a same-cycle write.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_cnt_d[i] = stat_cnt_q[i];
         if (stat_clr) begin
            stat_cnt_d[i] = '0;
         end else if (fifo_wr_en && (grant_id_q == ID_WIDTH'(i)) &&
                      (stat_cnt_q[i] != 16'hFFFF)) begin
            stat_cnt_d[i] = stat_cnt_q[i] + 16'd1;
         end
      end
   end

   // Selects beyond NUM_REQ read as zero.
   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_sel == ID_WIDTH'(i)) begin
            stat_count = stat_cnt_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt_q[i] <= stat_cnt_d[i];
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single producer bursts, round-robin
// fairness, FIFO-full stall, early release with pointer wrap, optional counters.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fifo_wr_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int IW = 2;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            fifo_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_data_in;
   logic            grant_valid;
   logic [IW-1:0]   grant_id;
`ifdef FIFO_ARB_STATS_EN
   logic [IW-1:0]   stat_sel;
   logic            stat_clr;
   logic [15:0]     stat_count;
`endif

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_sel     (stat_sel),
      .stat_clr     (stat_clr),
      .stat_count   (stat_count)
`endif
   );

   int passed = 0;
   int total  = 0;

   // Producer models: beats remaining and current data word.
   int         rem  [NR];
   logic [7:0] pdat [NR];

   // Values sampled in the most recent cycle.
   logic          s_wr;
   logic [7:0]    s_dat;
   logic [NR-1:0] s_rdy;
   logic          s_gv;
   logic [IW-1:0] s_gid;

   logic [7:0]    wr_dat [$];

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]           = (rem[i] > 0);
         req_data[i*DW +: DW]   = pdat[i];
      end
   endtask

   // One clock: sample at the falling edge, log writes, advance producers that handshook.
   task automatic cycle();
      logic [NR-1:0] hs;
      @(negedge clk);
      s_wr  = fifo_wr_en;
      s_dat = fifo_data_in;
      s_rdy = req_ready;
      s_gv  = grant_valid;
      s_gid = grant_id;
      hs    = req_valid & req_ready;
      if (s_wr) wr_dat.push_back(s_dat);
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (hs[i]) begin
            rem[i]  = rem[i] - 1;
            pdat[i] = pdat[i] + 8'd1;
         end
      end
      drive();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i]  = 100;
         pdat[i] = 8'(i * 16);
      end
      drive();
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         cycle();
         total++; if (s_wr !== 1'b0) $display("FAIL reset_wr_en cyc%0d got=%b exp=0", c, s_wr); else passed++;
         total++; if (s_rdy !== 4'b0000) $display("FAIL reset_ready cyc%0d got=%b exp=0000", c, s_rdy); else passed++;
         total++; if (s_gv !== 1'b0) $display("FAIL reset_grant_valid cyc%0d got=%b exp=0", c, s_gv); else passed++;
         total++; if (s_gid !== 2'd0) $display("FAIL reset_grant_id cyc%0d got=%0d exp=0", c, s_gid); else passed++;
      end
      rst = 1'b0;
      cycle();
      total++; if (s_gv !== 1'b0) $display("FAIL post_reset_arb_gv got=%b exp=0", s_gv); else passed++;
      cycle();
      total++; if (s_gv !== 1'b1) $display("FAIL first_grant_gv got=%b exp=1", s_gv); else passed++;
      total++; if (s_gid !== 2'd0) $display("FAIL first_grant_id got=%0d exp=0", s_gid); else passed++;
      total++; if (s_rdy !== 4'b0001) $display("FAIL first_grant_ready got=%b exp=0001", s_rdy); else passed++;
      total++; if (s_wr !== 1'b1 || s_dat !== 8'h00) $display("FAIL first_write got=%b/%h exp=1/00", s_wr, s_dat); else passed++;
   endtask

   task automatic test_reset_mid_burst();
      rst = 1'b1;
      cycle();
      total++; if (s_wr !== 1'b0) $display("FAIL midrst_wr_en got=%b exp=0", s_wr); else passed++;
      total++; if (s_rdy !== 4'b0000) $display("FAIL midrst_ready got=%b exp=0000", s_rdy); else passed++;
      cycle();
      total++; if (s_gv !== 1'b0) $display("FAIL midrst_idle_gv got=%b exp=0", s_gv); else passed++;
      rst = 1'b0;
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      cycle();
      total++; if (s_gv !== 1'b0 || s_wr !== 1'b0) $display("FAIL idle_no_req got=%b/%b exp=0/0", s_gv, s_wr); else passed++;
   endtask

   task automatic test_single_producer();
      logic [13:0] pat;
      wr_dat.delete();
      rem[2]  = 10;
      pdat[2] = 8'h20;
      drive();
      for (int c = 0; c < 14; c++) begin
         cycle();
         pat[c] = s_wr;
      end
      total++; if (pat !== 14'b01101111011110) $display("FAIL single_wr_pattern got=%b exp=01101111011110", pat); else passed++;
      total++; if (wr_dat.size() != 10) $display("FAIL single_count got=%0d exp=10", wr_dat.size()); else passed++;
      if (wr_dat.size() == 10) begin
         for (int k = 0; k < 10; k++) begin
            total++; if (wr_dat[k] !== 8'(8'h20 + k)) $display("FAIL single_data[%0d] got=%h exp=%h", k, wr_dat[k], 8'(8'h20 + k)); else passed++;
         end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_rr [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                                  8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
                                  8'h04, 8'h05, 8'h06, 8'h07};
      reset_pulse();
      wr_dat.delete();
      for (int i = 0; i < NR; i++) begin
         rem[i]  = 10;
         pdat[i] = 8'(i * 16);
      end
      drive();
      for (int c = 0; c < 120 && wr_dat.size() < 40; c++) cycle();
      cycle();
      cycle();
      total++; if (wr_dat.size() != 40) $display("FAIL rr_count got=%0d exp=40", wr_dat.size()); else passed++;
      if (wr_dat.size() >= 40) begin
         for (int k = 0; k < 20; k++) begin
            total++; if (wr_dat[k] !== exp_rr[k]) $display("FAIL rr_data[%0d] got=%h exp=%h", k, wr_dat[k], exp_rr[k]); else passed++;
         end
         total++; if (wr_dat[38] !== 8'h38 || wr_dat[39] !== 8'h39) $display("FAIL rr_tail got=%h,%h exp=38,39", wr_dat[38], wr_dat[39]); else passed++;
      end
`ifdef FIFO_ARB_STATS_EN
      for (int s = 0; s < NR; s++) begin
         stat_sel = IW'(s);
         @(negedge clk);
         total++; if (stat_count !== 16'd10) $display("FAIL stat_count[%0d] got=%0d exp=10", s, stat_count); else passed++;
         @(posedge clk);
         #1;
      end
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      for (int s = 0; s < NR; s++) begin
         stat_sel = IW'(s);
         @(negedge clk);
         total++; if (stat_count !== 16'd0) $display("FAIL stat_clr[%0d] got=%0d exp=0", s, stat_count); else passed++;
         @(posedge clk);
         #1;
      end
`endif
   endtask

   task automatic test_backpressure();
      reset_pulse();
      wr_dat.delete();
      rem[1]  = 4;
      pdat[1] = 8'h40;
      rem[2]  = 1;
      pdat[2] = 8'h50;
      drive();
      cycle();
      total++; if (s_gv !== 1'b0) $display("FAIL bp_arb_gv got=%b exp=0", s_gv); else passed++;
      cycle();
      total++; if (s_gid !== 2'd1 || s_wr !== 1'b1 || s_dat !== 8'h40) $display("FAIL bp_beat0 got=%0d/%b/%h exp=1/1/40", s_gid, s_wr, s_dat); else passed++;
      cycle();
      total++; if (s_wr !== 1'b1 || s_dat !== 8'h41) $display("FAIL bp_beat1 got=%b/%h exp=1/41", s_wr, s_dat); else passed++;
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         total++; if (s_wr !== 1'b0 || s_rdy !== 4'b0000) $display("FAIL bp_stall%0d wr/ready got=%b/%b exp=0/0000", c, s_wr, s_rdy); else passed++;
         total++; if (s_gv !== 1'b1 || s_gid !== 2'd1) $display("FAIL bp_stall%0d grant got=%b/%0d exp=1/1", c, s_gv, s_gid); else passed++;
      end
      fifo_full = 1'b0;
      cycle();
      total++; if (s_wr !== 1'b1 || s_dat !== 8'h42 || s_rdy !== 4'b0010) $display("FAIL bp_beat2 got=%b/%h/%b exp=1/42/0010", s_wr, s_dat, s_rdy); else passed++;
      cycle();
      total++; if (s_wr !== 1'b1 || s_dat !== 8'h43) $display("FAIL bp_beat3 got=%b/%h exp=1/43", s_wr, s_dat); else passed++;
      cycle();
      total++; if (s_gv !== 1'b0) $display("FAIL bp_release_gv got=%b exp=0", s_gv); else passed++;
      cycle();
      total++; if (s_gid !== 2'd2 || s_wr !== 1'b1 || s_dat !== 8'h50) $display("FAIL bp_next_grant got=%0d/%b/%h exp=2/1/50", s_gid, s_wr, s_dat); else passed++;
      cycle();
   endtask

   task automatic test_wrap();
      rem[3]  = 1;
      pdat[3] = 8'h60;
      rem[0]  = 1;
      pdat[0] = 8'h70;
      drive();
      cycle();
      total++; if (s_gv !== 1'b0) $display("FAIL wrap_arb_gv got=%b exp=0", s_gv); else passed++;
      cycle();
      total++; if (s_gid !== 2'd3 || s_wr !== 1'b1 || s_dat !== 8'h60) $display("FAIL wrap_p3 got=%0d/%b/%h exp=3/1/60", s_gid, s_wr, s_dat); else passed++;
      cycle();
      total++; if (s_gv !== 1'b1 || s_wr !== 1'b0) $display("FAIL wrap_drop got=%b/%b exp=1/0", s_gv, s_wr); else passed++;
      cycle();
      total++; if (s_gv !== 1'b0) $display("FAIL wrap_idle got=%b exp=0", s_gv); else passed++;
      cycle();
      total++; if (s_gid !== 2'd0 || s_wr !== 1'b1 || s_dat !== 8'h70) $display("FAIL wrap_p0 got=%0d/%b/%h exp=0/1/70", s_gid, s_wr, s_dat); else passed++;
      cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      fifo_full = 1'b0;
      req_valid = '0;
      req_data  = '0;
`ifdef FIFO_ARB_STATS_EN
      stat_sel  = '0;
      stat_clr  = 1'b0;
`endif
      test_reset();
      test_reset_mid_burst();
      test_single_producer();
      test_round_robin();
      test_backpressure();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
